// File: rtl/add_serial_pkg.sv
// Shared definitions for the serial add/subtract family: FSM encoding and operand masks.
// The delay states exist only to absorb bad-key starts without producing a result.
package add_serial_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        DONE = 3'd2,
        DLY0 = 3'd3,
        DLY1 = 3'd4,
        DLY2 = 3'd5,
        DLY3 = 3'd6,
        DLY4 = 3'd7
    } state_t;

    localparam logic [7:0] A_MASK_DEF = 8'h18;
    localparam logic [7:0] B_MASK_DEF = 8'hDB;
    localparam logic [7:0] KEY_DEF    = 8'hA5;

endpackage

// File: rtl/serial_fs.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column underflows.
// Purely combinational, no flow control.
module serial_fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial LSB-first subtractor, result and borrow valid WIDTH cycles after a keyed capture.
// A wrong key sends the FSM through a five-state delay chain back to IDLE with no result.
module sub_serial
    import add_serial_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] A_MASK = A_MASK_DEF[WIDTH-1:0],
    parameter logic [WIDTH-1:0] B_MASK = B_MASK_DEF[WIDTH-1:0],
    parameter logic [7:0]       KEY    = KEY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       key,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             brw_q, brw_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    logic fs_d;
    logic fs_bout;

    serial_fs u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        count_d  = count_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        done_d   = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    out_d    = '0;
                    done_d   = 1'b0;
                    borrow_d = 1'b0;
                    if (key == KEY) begin
                        a_d     = a ^ A_MASK;
                        b_d     = b ^ B_MASK;
                        brw_d   = 1'b0;
                        count_d = '0;
                        state_d = SUB;
                    end else begin
                        state_d = DLY0;
                    end
                end
            end
            SUB: begin
                out_d   = {fs_d, out_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                brw_d   = fs_bout;
                count_d = count_q + CW'(1);
                // Final borrow comes from this cycle's cell, not the registered one
                if (count_q == LAST) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    borrow_d = fs_bout;
                end
            end
            DLY0: state_d = DLY1;
            DLY1: state_d = DLY2;
            DLY2: state_d = DLY3;
            DLY3: state_d = DLY4;
            DLY4: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            count_q  <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            count_q  <= count_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign out    = out_q;
    assign borrow = borrow_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: directed cases plus randomized traffic against a timeline model.
module tb_sub_serial;

    localparam logic [7:0] AM   = 8'h18;
    localparam logic [7:0] BM   = 8'hDB;
    localparam logic [7:0] KEYV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] key = 8'h00;
    logic [7:0] a   = 8'h00;
    logic [7:0] b   = 8'h00;
    logic [7:0] out;
    logic       borrow;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    sub_serial dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .key    (key),
        .a      (a),
        .b      (b),
        .out    (out),
        .borrow (borrow),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: cycles left until a result appears, or until the decoy finishes.
    int         m_sub_left = 0;
    int         m_dly_left = 0;
    logic       m_done     = 1'b0;
    logic [7:0] m_out      = 8'h00;
    logic       m_borrow   = 1'b0;
    logic [7:0] p_out;
    logic       p_borrow;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sub_left = 0;
            m_dly_left = 0;
            m_done     = 1'b0;
            m_out      = 8'h00;
            m_borrow   = 1'b0;
        end else if (m_sub_left > 0) begin
            m_sub_left--;
            if (m_sub_left == 0) begin
                m_done   = 1'b1;
                m_out    = p_out;
                m_borrow = p_borrow;
            end
        end else if (m_dly_left > 0) begin
            m_dly_left--;
        end else if (en) begin
            m_done   = 1'b0;
            m_out    = 8'h00;
            m_borrow = 1'b0;
            if (key == KEYV) begin
                m_sub_left = 8;
                p_out      = 8'((a ^ AM) - (b ^ BM));
                p_borrow   = ((a ^ AM) < (b ^ BM));
            end else begin
                m_dly_left = 5;
            end
        end
    end

    // out is only meaningful outside a running subtraction
    always @(negedge clk) begin
        #1;
        if (chk_en && !rst) begin
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_borrow", {31'd0, borrow}, {31'd0, m_borrow});
            if (m_sub_left == 0)
                chk("model_out", {24'd0, out}, {24'd0, m_out});
        end
    end

    task automatic run(input string name, input logic [7:0] au, input logic [7:0] bu,
                       input bit noise, input logic [7:0] exp_out, input logic exp_brw);
        int n;
        @(negedge clk);
        a   = au ^ AM;
        b   = bu ^ BM;
        key = KEYV;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n  = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (noise && n < 8) begin
                en  = 1'($urandom_range(0, 1));
                key = 8'($urandom);
                a   = 8'($urandom);
                b   = 8'($urandom);
            end else begin
                en = 1'b0;
            end
            if (done) break;
        end
        chk({name, "_latency"}, n, 8);
        chk({name, "_out"}, {24'd0, out}, {24'd0, exp_out});
        chk({name, "_borrow"}, {31'd0, borrow}, {31'd0, exp_brw});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_out", {24'd0, out}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_borrow", {31'd0, borrow}, 0);
        chk("reset_state", {29'd0, dut.state_q}, 0);

        run("c1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run("c2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        run("c2b", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);

        // Wrong key, then hold en with the right key: capture only once back in IDLE
        @(negedge clk);
        a   = 8'h05 ^ AM;
        b   = 8'h03 ^ BM;
        key = 8'h5A;
        en  = 1'b1;
        @(negedge clk);
        key = KEYV;
        chk("c3_state0", {29'd0, dut.state_q}, 3);
        chk("c3_done0", {31'd0, done}, 0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("c3_state", {29'd0, dut.state_q}, (i < 5) ? 32'(3 + i) : 32'd0);
            chk("c3_out", {24'd0, out}, 0);
            chk("c3_done", {31'd0, done}, 0);
            chk("c3_borrow", {31'd0, borrow}, 0);
        end
        @(negedge clk);
        en = 1'b0;
        chk("c3_capture", {29'd0, dut.state_q}, 1);
        n = 6;
        while (n < 40 && !done) begin
            @(negedge clk);
            n++;
        end
        chk("c3_latency", n, 14);
        chk("c3_out_after", {24'd0, out}, 8'h02);

        // Reset four cycles into SUB
        @(negedge clk);
        a   = 8'h05 ^ AM;
        b   = 8'h03 ^ BM;
        key = KEYV;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("c4_out", {24'd0, out}, 0);
        chk("c4_done", {31'd0, done}, 0);
        chk("c4_state", {29'd0, dut.state_q}, 0);
        @(negedge clk);
        rst = 1'b0;
        run("c4_run", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

        // Back-to-back restart from DONE
        chk("c5_done_before", {31'd0, done}, 1);
        a   = 8'hFF ^ AM;
        b   = 8'hFF ^ BM;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("c5_done_drop", {31'd0, done}, 0);
        n = 0;
        while (n < 30 && !done) begin
            @(negedge clk);
            n++;
        end
        chk("c5_latency", n, 8);
        chk("c5_out", {24'd0, out}, 8'h00);
        chk("c5_borrow", {31'd0, borrow}, 0);

        run("c6", 8'h05, 8'h03, 1'b1, 8'h02, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 3) == 0);
            key = ($urandom_range(0, 3) != 0) ? KEYV : 8'($urandom);
            a   = 8'($urandom);
            b   = 8'($urandom);
            rst = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
